rv32i_mem_arbiter: RTL



---
 rtl/rv32i_mem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Memory bus arbiter for rv32i: instruction fetch vs. ALU load/store, with a data-first starvation guard.
// Optional performance counters are built when RV32_ARB_PERF_EN is defined.
module rv32i_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_load,
    input  logic              d_store,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              stall,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_waitreq,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdvalid
`ifdef RV32_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [15:0]       perf_starve_grants
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_DCMD, S_ICMD, S_RDWAIT, S_DONE} state_t;

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    state_t            r_state;
    logic              r_is_data;
    logic              r_is_write;
    logic [3:0]        r_starve_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_d_rdata;
    logic [31:0]       r_i_rdata;
    logic              r_d_done;
    logic              r_i_valid;

    logic w_d_req;
    logic w_force_fetch;
    logic w_pulse;
    logic w_grant_d;
    logic w_grant_i;
    logic w_accept;
    logic w_rd_capture;

    assign w_d_req       = d_load | d_store;
    assign w_force_fetch = i_req && (r_starve_cnt == C_STARVE_MAX);
    // The requester that just finished still shows its old request during its pulse cycle.
    assign w_pulse       = r_d_done | r_i_valid;
    assign w_grant_d     = (r_state == S_IDLE) && !w_pulse && w_d_req && !w_force_fetch;
    assign w_grant_i     = (r_state == S_IDLE) && !w_pulse && i_req && !w_grant_d;
    assign w_accept      = ((r_state == S_DCMD) || (r_state == S_ICMD)) && !mem_waitreq;
    assign w_rd_capture  = mem_rdvalid && ((w_accept && !r_is_write) || (r_state == S_RDWAIT));

    assign stall     = w_d_req & ~r_d_done;
    assign d_done    = r_d_done;
    assign i_valid   = r_i_valid;
    assign d_rdata   = r_d_rdata;
    assign i_rdata   = r_i_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_is_data    <= 1'b0;
            r_is_write   <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_addr   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_d_rdata    <= '0;
            r_i_rdata    <= '0;
            r_d_done     <= 1'b0;
            r_i_valid    <= 1'b0;
        end else begin
            r_d_done  <= 1'b0;
            r_i_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= S_DCMD;
                        r_is_data   <= 1'b1;
                        r_is_write  <= d_store;
                        r_mem_addr  <= d_addr;
                        r_mem_read  <= ~d_store;
                        r_mem_write <= d_store;
                        r_mem_be    <= d_store ? d_be : 4'hf;
                        r_mem_wdata <= d_wdata;
                        if (i_req)
                            r_starve_cnt <= (r_starve_cnt == C_STARVE_MAX) ? r_starve_cnt
                                                                           : r_starve_cnt + 4'd1;
                        else
                            r_starve_cnt <= '0;
                    end else if (w_grant_i) begin
                        r_state      <= S_ICMD;
                        r_is_data    <= 1'b0;
                        r_is_write   <= 1'b0;
                        r_mem_addr   <= i_addr;
                        r_mem_read   <= 1'b1;
                        r_mem_write  <= 1'b0;
                        r_mem_be     <= 4'hf;
                        r_mem_wdata  <= '0;
                        r_starve_cnt <= '0;
                    end
                end
                S_DCMD, S_ICMD: begin
                    if (!mem_waitreq) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        // Read data arriving with acceptance skips RDWAIT.
                        r_state     <= (r_is_write || mem_rdvalid) ? S_DONE : S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (mem_rdvalid)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (r_is_data)
                        r_d_done <= 1'b1;
                    else
                        r_i_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_rd_capture) begin
                if (r_is_data)
                    r_d_rdata <= mem_rdata;
                else
                    r_i_rdata <= mem_rdata;
            end
        end
    end

`ifdef RV32_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_starve;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_stall  <= '0;
            r_perf_starve <= '0;
        end else begin
            if (stall)
                r_perf_stall <= r_perf_stall + 32'd1;
            // Forced only when data was also asking and lost to the guard.
            if (w_grant_i && w_force_fetch && w_d_req)
                r_perf_starve <= r_perf_starve + 16'd1;
        end
    end

    assign perf_stall_cycles  = r_perf_stall;
    assign perf_starve_grants = r_perf_starve;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && w_grant_d && d_load && d_store)
            $display("rv32i_mem_arbiter: d_load and d_store both high, servicing as store");
    end
`endif

endmodule
